// File: rtl/btn_pkg.sv
// btn_pkg: shared types, defaults and round-robin pick for the button event arbiter
package btn_pkg;
  typedef enum logic {IDLE, OFFER} arb_state_t;
  localparam int N_BTN_DEF = 4;
  localparam int DB_CYCLES_DEF = 500000;
  localparam int MAX_BTN = 8;
  localparam int MAX_ID_W = 3;
  function automatic int rr_pick(input logic [MAX_BTN-1:0] pend, input int ptr, input int n);
    int sel = 0;
    for (int k = n - 1; k >= 0; k--)
      if (pend[MAX_ID_W'((ptr + k) % n)]) sel = (ptr + k) % n;
    return sel;
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchronizer, stable-count debounce and rise pulse for one button
module btn_debounce #(
  parameter int DB_CYCLES = 4,
  localparam int CNT_W = $clog2(DB_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);
  logic s1, sync;
  logic [CNT_W-1:0] cnt;
  logic hit;
  assign hit = (sync != level) && (cnt == CNT_W'(DB_CYCLES - 1));
  assign rise = hit & ~level;
  // metastability guard; left unreset so it tracks the pin through reset
  always_ff @(posedge clk) begin
    s1 <= raw;
    sync <= s1;
  end
  // count consecutive disagreeing cycles, flip the level once the count is reached
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      level <= 1'b0;
    end else begin
      cnt <= (sync == level || hit) ? '0 : cnt + 1'b1;
      level <= level ^ hit;
    end
  end
endmodule

// File: rtl/btn_event_arbiter.sv
// btn_event_arbiter: debounced button presses queued as pending bits and offered round-robin
module btn_event_arbiter
  import btn_pkg::*;
#(
  parameter int N_BTN = N_BTN_DEF,
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  localparam int ID_W = $clog2(N_BTN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic            evt_valid,
  output logic [ID_W-1:0] evt_id,
  input  logic            evt_ready,
  output logic            evt_overflow
);
  arb_state_t state, state_n;
  logic [N_BTN-1:0] rise, pending, pend_n, clr;
  logic [ID_W-1:0] rr_ptr, ptr_n, id_n;
  logic ovf_n;
  for (genvar i = 0; i < N_BTN; i++) begin : g_db
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk(clk),
      .rst_n(rst_n),
      .raw(btn_raw[i]),
      .level(btn_level[i]),
      .rise(rise[i])
    );
  end
  assign evt_valid = (state == OFFER);
  // pending update, coalesce detection and arbiter next state
  always_comb begin
    clr = '0;
    if (state == OFFER && evt_ready) clr[evt_id] = 1'b1;
    pend_n = (pending & ~clr) | rise;
    ovf_n = |(rise & pending & ~clr);
    state_n = state;
    id_n = evt_id;
    ptr_n = rr_ptr;
    if (state == IDLE && |pending) begin
      state_n = OFFER;
      id_n = ID_W'(rr_pick(MAX_BTN'(pending), int'(rr_ptr), N_BTN));
    end else if (state == OFFER && evt_ready) begin
      state_n = IDLE;
      ptr_n = (evt_id == ID_W'(N_BTN - 1)) ? '0 : evt_id + 1'b1;
    end
  end
  // arbiter and pending state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pending <= '0;
      rr_ptr <= '0;
      evt_id <= '0;
      evt_overflow <= 1'b0;
    end else begin
      state <= state_n;
      pending <= pend_n;
      rr_ptr <= ptr_n;
      evt_id <= id_n;
      evt_overflow <= ovf_n;
    end
  end
endmodule

// File: tb/tb_btn_event_arbiter.sv
// tb_btn_event_arbiter: directed vector table plus corner-case sequences for btn_event_arbiter
module tb_btn_event_arbiter;
  localparam int DB = 4;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] btn_raw;
  logic [3:0] btn_level;
  logic evt_valid;
  logic [1:0] evt_id;
  logic evt_ready;
  logic evt_overflow;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [3:0] raw;
    logic ready;
    logic [3:0] lvl;
    logic v;
    logic [1:0] id;
    logic ovf;
  } vec_t;
  vec_t tbl[$];
  btn_event_arbiter #(.N_BTN(4), .DB_CYCLES(DB)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .evt_valid(evt_valid),
    .evt_id(evt_id),
    .evt_ready(evt_ready),
    .evt_overflow(evt_overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic add(input int n, input logic [3:0] raw, input logic ready, input logic [3:0] lvl,
                     input logic v, input logic [1:0] id, input logic ovf);
    repeat (n) tbl.push_back('{raw, ready, lvl, v, id, ovf});
  endtask
  task automatic step(input logic [3:0] raw, input logic ready);
    btn_raw = raw;
    evt_ready = ready;
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_id", 32'(evt_id), 0);
    chk("rst_level", 32'(btn_level), 0);
    chk("rst_pending", 32'(dut.pending), 0);
    chk("rst_ovf", 32'(evt_overflow), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    int ids[3] = '{3, 0, 1};
    int ovfs;
    int n;
    btn_raw = '0;
    evt_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_level", 32'(btn_level), 0);
    chk("reset_valid", 32'(evt_valid), 0);
    chk("reset_id", 32'(evt_id), 0);
    chk("reset_ovf", 32'(evt_overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    // clean press on button 2 and release
    add(5, 4'b0100, 1, 4'b0000, 0, 0, 0);
    add(1, 4'b0100, 1, 4'b0100, 0, 0, 0);
    add(1, 4'b0100, 1, 4'b0100, 1, 2, 0);
    add(2, 4'b0100, 1, 4'b0100, 0, 2, 0);
    add(5, 4'b0000, 1, 4'b0100, 0, 2, 0);
    add(2, 4'b0000, 1, 4'b0000, 0, 2, 0);
    // bouncing press on button 0, then release
    add(1, 4'b0001, 1, 4'b0000, 0, 2, 0);
    add(1, 4'b0000, 1, 4'b0000, 0, 2, 0);
    add(1, 4'b0001, 1, 4'b0000, 0, 2, 0);
    add(1, 4'b0000, 1, 4'b0000, 0, 2, 0);
    add(5, 4'b0001, 1, 4'b0000, 0, 2, 0);
    add(1, 4'b0001, 1, 4'b0001, 0, 2, 0);
    add(1, 4'b0001, 1, 4'b0001, 1, 0, 0);
    add(1, 4'b0001, 1, 4'b0001, 0, 0, 0);
    add(5, 4'b0000, 1, 4'b0001, 0, 0, 0);
    add(2, 4'b0000, 1, 4'b0000, 0, 0, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].raw, tbl[i].ready);
      chk($sformatf("vec%0d_level", i), 32'(btn_level), 32'(tbl[i].lvl));
      chk($sformatf("vec%0d_valid", i), 32'(evt_valid), 32'(tbl[i].v));
      chk($sformatf("vec%0d_id", i), 32'(evt_id), 32'(tbl[i].id));
      chk($sformatf("vec%0d_ovf", i), 32'(evt_overflow), 32'(tbl[i].ovf));
    end
    // round robin: consume button 1 to move pointer to 2, then 0,1,3 together
    repeat (6) step(4'b0010, 1);
    chk("rr_pre_level", 32'(btn_level), 32'h2);
    step(4'b0010, 1);
    chk("rr_pre_valid", 32'(evt_valid), 1);
    chk("rr_pre_id", 32'(evt_id), 1);
    step(4'b0010, 1);
    chk("rr_pre_done", 32'(evt_valid), 0);
    repeat (7) step(4'b0000, 1);
    chk("rr_pre_release", 32'(btn_level), 0);
    repeat (6) step(4'b1011, 1);
    chk("rr_level", 32'(btn_level), 32'hb);
    chk("rr_no_valid_yet", 32'(evt_valid), 0);
    for (int k = 0; k < 6; k++) begin
      step(4'b1011, 1);
      chk($sformatf("rr_valid%0d", k), 32'(evt_valid), 32'((k % 2) == 0));
      if ((k % 2) == 0) chk($sformatf("rr_id%0d", k), 32'(evt_id), 32'(ids[k / 2]));
      chk($sformatf("rr_ovf%0d", k), 32'(evt_overflow), 0);
    end
    chk("rr_ptr_final", 32'(dut.rr_ptr), 2);
    repeat (7) step(4'b0000, 1);
    chk("rr_release", 32'(btn_level), 0);
    // back-pressure: press, release, press again on button 1 while not ready
    repeat (7) step(4'b0010, 0);
    chk("bp_valid", 32'(evt_valid), 1);
    chk("bp_id", 32'(evt_id), 1);
    ovfs = 0;
    repeat (7) begin
      step(4'b0000, 0);
      chk("bp_hold_valid", 32'(evt_valid), 1);
      chk("bp_hold_id", 32'(evt_id), 1);
      ovfs += int'(evt_overflow);
    end
    chk("bp_released", 32'(btn_level), 0);
    repeat (9) begin
      step(4'b0010, 0);
      chk("bp_repress_valid", 32'(evt_valid), 1);
      chk("bp_repress_id", 32'(evt_id), 1);
      ovfs += int'(evt_overflow);
    end
    chk("bp_ovf_count", 32'(ovfs), 1);
    step(4'b0010, 1);
    chk("bp_accept", 32'(evt_valid), 0);
    repeat (4) begin
      step(4'b0010, 1);
      chk("bp_single_event", 32'(evt_valid), 0);
    end
    chk("bp_pending_clear", 32'(dut.pending), 0);
    repeat (7) step(4'b0000, 1);
    // reset mid-offer with the button already released
    repeat (7) step(4'b1000, 0);
    chk("rs1_valid", 32'(evt_valid), 1);
    chk("rs1_id", 32'(evt_id), 3);
    repeat (7) step(4'b0000, 0);
    chk("rs1_level_low", 32'(btn_level), 0);
    pulse_reset();
    repeat (10) begin
      step(4'b0000, 1);
      chk("rs1_no_event", 32'(evt_valid), 0);
    end
    // reset mid-offer with the button held through reset
    repeat (7) step(4'b1000, 0);
    chk("rs2_valid", 32'(evt_valid), 1);
    chk("rs2_id", 32'(evt_id), 3);
    pulse_reset();
    n = 0;
    while (!evt_valid && n < 20) begin
      step(4'b1000, 0);
      n++;
    end
    chk("rs2_latency_in_range", 32'(n >= DB && n <= DB + 2), 1);
    chk("rs2_id_after", 32'(evt_id), 3);
    step(4'b1000, 1);
    chk("rs2_accept", 32'(evt_valid), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
